prog_loader: RTL

- Writer-side counterpart to the mini-MCU program ROM.
- Receives a framed byte stream, for example from the UART RX path, and assembles 18-bit instruction words.
- Writes the words sequentially into the program RAM that replaces the ROM, using that RAM's 12-bit address / 18-bit data write port.
- Holds the MCU in reset while loading and releases it only after a frame passes its checksum.

---
 rtl/prog_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: assembles 18-bit words into program RAM and
// holds the MCU in reset until a frame passes its checksum.
//
//   state   | meaning
//   IDLE    | hunting for SYNC_BYTE, other bytes dropped
//   LEN_H   | awaiting word count high byte
//   LEN_L   | awaiting word count low byte, range check
//   B0..B2  | awaiting word bytes (B0 carries data[17:16])
//   WRITE   | one-cycle RAM write strobe
//   CHK     | awaiting checksum byte
//   DONE    | load good, release MCU
//   ERROR   | frame aborted
module prog_loader #(
  parameter int          ADDR_W    = 12,
  parameter int          DATA_W    = 18,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          TIMEOUT   = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] prog_data,
  output logic              prog_we,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   word_count
);

  localparam int          TMR_W   = $clog2(TIMEOUT + 1);
  localparam logic [15:0] LEN_MAX = 16'(1 << ADDR_W);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_H, S_LEN_L, S_B0, S_B1, S_B2, S_WRITE, S_CHK, S_DONE, S_ERROR
  } state_t;

  state_t            state, state_next;
  logic [15:0]       len_q;
  logic [7:0]        chk_q;
  logic [1:0]        b0_q;
  logic [7:0]        b1_q;
  logic [ADDR_W-1:0] addr_cnt;
  logic [TMR_W-1:0]  timer;
  logic              hs;
  logic              timed;
  logic              ready_next;
  logic [15:0]       len_full;
  logic [15:0]       wc_ext;

  assign hs       = rx_valid && rx_ready;
  assign len_full = {len_q[15:8], rx_data};
  assign wc_ext   = 16'(word_count);
  assign timed    = (state == S_LEN_H) || (state == S_LEN_L) || (state == S_B0) ||
                    (state == S_B1) || (state == S_B2) || (state == S_CHK);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (hs && rx_data == SYNC_BYTE) state_next = S_LEN_H;
      S_LEN_H: if (hs) state_next = S_LEN_L;
      S_LEN_L: if (hs) state_next = (len_full == 16'd0 || len_full > LEN_MAX) ? S_ERROR : S_B0;
      S_B0:    if (hs) state_next = (rx_data[7:2] != 6'd0) ? S_ERROR : S_B1;
      S_B1:    if (hs) state_next = S_B2;
      S_B2:    if (hs) state_next = S_WRITE;
      S_WRITE: state_next = (wc_ext + 16'd1 == len_q) ? S_CHK : S_B0;
      S_CHK:   if (hs) state_next = (rx_data == chk_q) ? S_DONE : S_ERROR;
      S_DONE:  state_next = S_IDLE;
      S_ERROR: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // An idle gap inside a frame aborts it regardless of state.
    if (timed && !hs && timer == TMR_W'(TIMEOUT)) state_next = S_ERROR;
  end

  always_comb begin
    ready_next = 1'b0;
    case (state_next)
      S_IDLE, S_LEN_H, S_LEN_L, S_B0, S_B1, S_B2, S_CHK: ready_next = 1'b1;
      default: ready_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rx_ready   <= 1'b0;
      prog_addr  <= '0;
      prog_data  <= '0;
      prog_we    <= 1'b0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      word_count <= '0;
      len_q      <= '0;
      chk_q      <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      addr_cnt   <= '0;
      timer      <= '0;
    end else begin
      state    <= state_next;
      rx_ready <= ready_next;
      prog_we  <= (state_next == S_WRITE);

      if (!timed || hs) timer <= '0;
      else              timer <= timer + TMR_W'(1);

      case (state)
        S_IDLE: if (hs && rx_data == SYNC_BYTE) begin
          cpu_reset  <= 1'b1;
          load_done  <= 1'b0;
          load_error <= 1'b0;
          chk_q      <= '0;
          word_count <= '0;
          addr_cnt   <= '0;
        end
        S_LEN_H: if (hs) begin
          len_q[15:8] <= rx_data;
          chk_q       <= chk_q + rx_data;
        end
        S_LEN_L: if (hs) begin
          len_q[7:0] <= rx_data;
          chk_q      <= chk_q + rx_data;
        end
        S_B0: if (hs) begin
          b0_q  <= rx_data[1:0];
          chk_q <= chk_q + rx_data;
        end
        S_B1: if (hs) begin
          b1_q  <= rx_data;
          chk_q <= chk_q + rx_data;
        end
        // Address and data are latched here so they are stable through WRITE and after.
        S_B2: if (hs) begin
          prog_addr <= addr_cnt;
          prog_data <= {b0_q, b1_q, rx_data};
          chk_q     <= chk_q + rx_data;
        end
        S_WRITE: begin
          addr_cnt   <= addr_cnt + ADDR_W'(1);
          word_count <= word_count + (ADDR_W+1)'(1);
        end
        default: ;
      endcase

      if (state_next == S_DONE) begin
        load_done <= 1'b1;
        cpu_reset <= 1'b0;
      end
      if (state_next == S_ERROR) load_error <= 1'b1;
    end
  end

endmodule
